// File: rtl/mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_rr
// Brief    : N-channel memory arbiter (fixed priority or round-robin) with
//            registered memory strobes, one-cycle ack and optional timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         ch_req,
    input  logic [NUM_CH-1:0]         ch_we,
    input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]  ch_wdata,
    output logic [NUM_CH-1:0]         ch_ack,
    output logic [NUM_CH-1:0]         ch_err,
    output logic [DATA_W-1:0]         ch_rdata,
    output logic [$clog2(NUM_CH)-1:0] grant,
    output logic                      busy,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_data_write,
    input  logic                      mem_ack,
    input  logic [DATA_W-1:0]         mem_data_read
);

    localparam int                 c_GNT_W   = $clog2(NUM_CH);
    localparam logic [c_GNT_W-1:0] c_LAST_CH = c_GNT_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_GNT_W-1:0]  ptr_q, ptr_d;
    logic [c_GNT_W-1:0]  grant_q, grant_d;
    logic [NUM_CH-1:0]   ch_ack_q, ch_ack_d;
    logic [NUM_CH-1:0]   ch_err_q, ch_err_d;
    logic [DATA_W-1:0]   ch_rdata_q, ch_rdata_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                w_any_req;
    logic                w_found;
    logic [c_GNT_W-1:0]  w_idx;
    logic [c_GNT_W-1:0]  w_winner;
    logic                w_timeout_hit;
    logic [ADDR_W-1:0]   w_addr_arr  [NUM_CH];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_CH];

    // Split the packed per-channel buses into indexable arrays
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = ch_addr[gi*ADDR_W +: ADDR_W];
            assign w_wdata_arr[gi] = ch_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign w_any_req = |ch_req;

    // Winner search: start one past the pointer and wrap. Fixed priority is
    // the same search anchored at the last channel, so channel 0 comes first.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = (RR_MODE != 0) ? ptr_q : c_LAST_CH;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = (w_idx == c_LAST_CH) ? '0 : w_idx + 1'b1;
            if (!w_found && ch_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // BUSY-cycle counter; only present when a timeout is configured
    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int c_CNT_W = $clog2(TIMEOUT + 1);
            logic [c_CNT_W-1:0] cnt_q;

            // Count cycles spent in BUSY, clear everywhere else
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (state_q == S_BUSY) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= '0;
                end
            end

            // Counter holds n-1 during BUSY cycle n, so this fires in cycle TIMEOUT
            assign w_timeout_hit = (state_q == S_BUSY) &&
                                   (cnt_q == c_CNT_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout_hit = 1'b0;
        end
    endgenerate

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        ch_ack_d    = '0;
        ch_err_d    = '0;
        ch_rdata_d  = ch_rdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                if (w_any_req) begin
                    state_d    = S_BUSY;
                    grant_d    = w_winner;
                    ptr_d      = w_winner;
                    mem_addr_d = w_addr_arr[w_winner];
                    if (ch_we[w_winner]) begin
                        mem_write_d = 1'b1;
                        mem_wdata_d = w_wdata_arr[w_winner];
                    end else begin
                        mem_read_d  = 1'b1;
                    end
                end
            end

            S_BUSY: begin
                // A real ack in the timeout cycle takes precedence
                if (mem_ack) begin
                    state_d           = S_DONE;
                    mem_read_d        = 1'b0;
                    mem_write_d       = 1'b0;
                    ch_ack_d[grant_q] = 1'b1;
                    if (mem_read_q) begin
                        ch_rdata_d = mem_data_read;
                    end
                end else if (w_timeout_hit) begin
                    state_d           = S_DONE;
                    mem_read_d        = 1'b0;
                    mem_write_d       = 1'b0;
                    ch_ack_d[grant_q] = 1'b1;
                    ch_err_d[grant_q] = 1'b1;
                    ch_rdata_d        = '0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= c_LAST_CH;
            grant_q     <= '0;
            ch_ack_q    <= '0;
            ch_err_q    <= '0;
            ch_rdata_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            ch_ack_q    <= ch_ack_d;
            ch_err_q    <= ch_err_d;
            ch_rdata_q  <= ch_rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ch_ack         = ch_ack_q;
    assign ch_err         = ch_err_q;
    assign ch_rdata       = ch_rdata_q;
    assign grant          = grant_q;
    assign busy           = (state_q != S_IDLE);
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data_write = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter_rr
// Brief    : Self-checking bench for mem_arbiter_rr (round-robin + timeout
//            instance and fixed-priority instance without timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

    localparam int c_N   = 3;
    localparam int c_TO  = 4;

    logic clk = 1'b0;
    logic reset;

    // Instance A: round-robin, TIMEOUT=4
    logic [c_N-1:0]    a_req, a_we, a_ack, a_err;
    logic [c_N*32-1:0] a_addr, a_wdata;
    logic [31:0]       a_rdata, a_maddr, a_mwdata, a_mrdata;
    logic [1:0]        a_grant;
    logic              a_busy, a_mrd, a_mwr, a_mack;

    // Instance B: fixed priority, no timeout
    logic [c_N-1:0]    b_req, b_we, b_ack, b_err;
    logic [c_N*32-1:0] b_addr, b_wdata;
    logic [31:0]       b_rdata, b_maddr, b_mwdata, b_mrdata;
    logic [1:0]        b_grant;
    logic              b_busy, b_mrd, b_mwr, b_mack;

    int n_checks = 0;
    int n_fail   = 0;
    int model_ptr;
    logic [31:0] model_rdata;

    typedef struct {
        int          ch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] mdata;
        int          exp_strobes;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl [6];

    mem_arbiter_rr #(.NUM_CH(c_N), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(c_TO)) dut_a (
        .clk(clk), .reset(reset), .ch_req(a_req), .ch_we(a_we), .ch_addr(a_addr),
        .ch_wdata(a_wdata), .ch_ack(a_ack), .ch_err(a_err), .ch_rdata(a_rdata),
        .grant(a_grant), .busy(a_busy), .mem_read(a_mrd), .mem_write(a_mwr),
        .mem_addr(a_maddr), .mem_data_write(a_mwdata), .mem_ack(a_mack),
        .mem_data_read(a_mrdata)
    );

    mem_arbiter_rr #(.NUM_CH(c_N), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset), .ch_req(b_req), .ch_we(b_we), .ch_addr(b_addr),
        .ch_wdata(b_wdata), .ch_ack(b_ack), .ch_err(b_err), .ch_rdata(b_rdata),
        .grant(b_grant), .busy(b_busy), .mem_read(b_mrd), .mem_write(b_mwr),
        .mem_addr(b_maddr), .mem_data_write(b_mwdata), .mem_ack(b_mack),
        .mem_data_read(b_mrdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arbitration: first requester after 'last', modulo N (or lowest index)
    function automatic int model_pick(input logic [c_N-1:0] req, input int last, input bit rr);
        if (!rr) begin
            for (int i = 0; i < c_N; i++) if (req[i]) return i;
            return -1;
        end
        for (int k = 1; k <= c_N; k++) begin
            if (req[(last + k) % c_N]) return (last + k) % c_N;
        end
        return -1;
    endfunction

    // Act as memory for instance A and check one full transaction
    task automatic a_observe(input int exp_ch, input int lat, input logic [31:0] mdata,
                             input int exp_strobes, input bit exp_err,
                             input logic [31:0] exp_rdata, input string tag,
                             output int first_cyc);
        int strobes = 0;
        bit seen    = 1'b0;
        first_cyc = -1;
        for (int cyc = 0; cyc < 30 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (a_ack != 0 || a_err != 0) begin
                seen   = 1'b1;
                a_mack = 1'b0;
                chk($sformatf("%s ack", tag), a_ack, 64'(1 << exp_ch));
                chk($sformatf("%s err", tag), a_err, exp_err ? 64'(1 << exp_ch) : 64'h0);
                chk($sformatf("%s rdata", tag), a_rdata, exp_rdata);
                chk($sformatf("%s strobe_cycles", tag), strobes, exp_strobes);
                chk($sformatf("%s strobes_low", tag), {a_mrd, a_mwr}, 2'b00);
                chk($sformatf("%s busy_done", tag), a_busy, 1'b1);
            end else if (a_mrd || a_mwr) begin
                if (strobes == 0) begin
                    first_cyc = cyc;
                    chk($sformatf("%s grant", tag), a_grant, exp_ch);
                    chk($sformatf("%s rd_wr", tag), {a_mrd, a_mwr}, {~a_we[exp_ch], a_we[exp_ch]});
                    if (a_we[exp_ch])
                        chk($sformatf("%s wdata", tag), a_mwdata, a_wdata[exp_ch*32 +: 32]);
                end
                chk($sformatf("%s addr", tag), a_maddr, a_addr[exp_ch*32 +: 32]);
                strobes++;
                a_mack   = (lat != 0 && strobes == lat);
                a_mrdata = a_mack ? mdata : $urandom;
            end else begin
                a_mack = 1'b0;
            end
        end
        if (!seen) chk($sformatf("%s ack_within_budget", tag), 0, 1);
    endtask

    // Act as memory for instance B; no timeout, so every transaction acks cleanly
    task automatic b_serve(input int exp_ch, input int lat, input logic [31:0] mdata, input string tag);
        int strobes = 0;
        bit seen    = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(posedge clk); #1;
            if (b_ack != 0 || b_err != 0) begin
                seen   = 1'b1;
                b_mack = 1'b0;
                chk($sformatf("%s ack", tag), b_ack, 64'(1 << exp_ch));
                chk($sformatf("%s err", tag), b_err, 0);
                chk($sformatf("%s rdata", tag), b_rdata, mdata);
                chk($sformatf("%s strobe_cycles", tag), strobes, lat);
            end else if (b_mrd || b_mwr) begin
                if (strobes == 0) begin
                    chk($sformatf("%s grant", tag), b_grant, exp_ch);
                    chk($sformatf("%s addr", tag), b_maddr, b_addr[exp_ch*32 +: 32]);
                end
                strobes++;
                b_mack   = (strobes == lat);
                b_mrdata = b_mack ? mdata : 32'h0;
            end
        end
        if (!seen) chk($sformatf("%s ack_within_budget", tag), 0, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fc;
        logic [c_N-1:0] pend;
        int exp_seq [6] = '{0, 1, 2, 0, 1, 2};

        tbl[0] = '{1, 1'b0, 32'h100, 32'h0,        3, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF};
        tbl[1] = '{0, 1'b1, 32'h40,  32'h12345678, 1, 32'h55555555, 1, 1'b0, 32'hDEADBEEF};
        tbl[2] = '{2, 1'b0, 32'h200, 32'h0,        0, 32'hCAFEBABE, 4, 1'b1, 32'h0};
        tbl[3] = '{1, 1'b1, 32'h300, 32'hAAAA5555, 4, 32'h11111111, 4, 1'b0, 32'h0};
        tbl[4] = '{0, 1'b0, 32'h10,  32'h0,        4, 32'h0BADF00D, 4, 1'b0, 32'h0BADF00D};
        tbl[5] = '{2, 1'b1, 32'h3FC, 32'h0F0F0F0F, 6, 32'h0,        4, 1'b1, 32'h0};

        a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_mack = 1'b0; a_mrdata = '0;
        b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_mack = 1'b0; b_mrdata = '0;
        reset = 1'b1;
        #2;
        chk("reset ch_ack", a_ack, 0);
        chk("reset ch_err", a_err, 0);
        chk("reset ch_rdata", a_rdata, 0);
        chk("reset grant", a_grant, 0);
        chk("reset busy", a_busy, 0);
        chk("reset mem_read", a_mrd, 0);
        chk("reset mem_write", a_mwr, 0);
        chk("reset mem_addr", a_maddr, 0);
        chk("reset mem_data_write", a_mwdata, 0);
        chk("reset B busy", b_busy, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_ptr   = c_N - 1;
        model_rdata = '0;

        // Single-channel transactions from the vector table
        foreach (tbl[i]) begin
            a_req[tbl[i].ch]               = 1'b1;
            a_we[tbl[i].ch]                = tbl[i].we;
            a_addr[tbl[i].ch*32 +: 32]     = tbl[i].addr;
            a_wdata[tbl[i].ch*32 +: 32]    = tbl[i].wdata;
            a_observe(tbl[i].ch, tbl[i].lat, tbl[i].mdata, tbl[i].exp_strobes,
                      tbl[i].exp_err, tbl[i].exp_rdata, $sformatf("vec%0d", i), fc);
            a_req[tbl[i].ch] = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d back_to_idle", i), a_busy, 0);
            chk($sformatf("vec%0d ack_one_cycle", i), a_ack, 0);
            model_ptr   = tbl[i].ch;
            model_rdata = tbl[i].exp_rdata;
        end

        // Round-robin with all channels requesting continuously
        a_we = '0;
        for (int c = 0; c < c_N; c++) a_addr[c*32 +: 32] = 32'h1000 + c;
        a_req = '1;
        for (int i = 0; i < 6; i++) begin
            a_observe(exp_seq[i], 1, 32'hC0DE0000 + i, 1, 1'b0, 32'hC0DE0000 + i,
                      $sformatf("rr%0d", i), fc);
            if (i > 0) chk($sformatf("rr%0d regrant_latency", i), fc, 1);
            model_ptr = exp_seq[i];
        end
        model_rdata = 32'hC0DE0005;
        a_req = '0;
        @(posedge clk); #1;

        // Reset in the middle of BUSY, then a late mem_ack
        a_req[1] = 1'b1; a_addr[1*32 +: 32] = 32'h500;
        for (int cyc = 0; cyc < 10 && !a_mrd; cyc++) begin
            @(posedge clk); #1;
        end
        chk("midreset strobe_up", a_mrd, 1);
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        chk("midreset busy", a_busy, 0);
        chk("midreset mem_read", a_mrd, 0);
        chk("midreset mem_addr", a_maddr, 0);
        chk("midreset grant", a_grant, 0);
        chk("midreset rdata", a_rdata, 0);
        a_req = '0;
        @(posedge clk); #1;
        reset    = 1'b0;
        a_mack   = 1'b1;
        a_mrdata = 32'hFFFFFFFF;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("late_ack%0d no_ack", i), a_ack, 0);
            chk($sformatf("late_ack%0d idle", i), a_busy, 0);
        end
        a_mack = 1'b0;
        model_ptr = c_N - 1;
        model_rdata = '0;
        // Channels 1 and 2 together: a restored pointer picks channel 1
        a_req = 3'b110; a_we = '0;
        a_addr[1*32 +: 32] = 32'h600; a_addr[2*32 +: 32] = 32'h700;
        a_observe(1, 2, 32'h61616161, 2, 1'b0, 32'h61616161, "post_reset1", fc);
        a_req[1] = 1'b0;
        a_observe(2, 1, 32'h72727272, 1, 1'b0, 32'h72727272, "post_reset2", fc);
        a_req[2] = 1'b0;
        model_ptr = 2;
        model_rdata = 32'h72727272;
        @(posedge clk); #1;

        // Fixed priority: channel 0 starves the others while it keeps requesting
        b_we = '0;
        for (int c = 0; c < c_N; c++) b_addr[c*32 +: 32] = 32'h2000 + c;
        b_req = '1;
        for (int i = 0; i < 4; i++) b_serve(0, 2, 32'hF0000000 + i, $sformatf("fp%0d", i));
        b_req[0] = 1'b0;
        b_serve(1, 8, 32'hF1F1F1F1, "fp_ch1_long");
        b_req[1] = 1'b0;
        b_serve(2, 1, 32'hF2F2F2F2, "fp_ch2");
        b_req = '0;

        // Randomized traffic on instance A against the reference model
        pend = '0;
        for (int it = 0; it < 40; it++) begin
            int w, lat, strobes;
            bit to;
            logic [31:0] md, er;
            for (int c = 0; c < c_N; c++) begin
                if (!pend[c] && ($urandom_range(0, 1) == 1)) begin
                    pend[c] = 1'b1;
                    a_we[c] = 1'($urandom_range(0, 1));
                    a_addr[c*32 +: 32]  = $urandom;
                    a_wdata[c*32 +: 32] = $urandom;
                    a_req[c] = 1'b1;
                end
            end
            if (pend == '0) begin
                w = $urandom_range(0, c_N - 1);
                pend[w] = 1'b1; a_we[w] = 1'b0; a_addr[w*32 +: 32] = $urandom; a_req[w] = 1'b1;
            end
            w   = model_pick(pend, model_ptr, 1'b1);
            lat = $urandom_range(0, 6);
            md  = $urandom;
            to  = (lat == 0) || (lat > c_TO);
            strobes = to ? c_TO : lat;
            er  = to ? 32'h0 : (a_we[w] ? model_rdata : md);
            a_observe(w, lat, md, strobes, to, er, $sformatf("rnd%0d", it), fc);
            model_ptr   = w;
            model_rdata = er;
            pend[w]  = 1'b0;
            a_req[w] = 1'b0;
        end
        a_req = '0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter_rr.md
# mem_arbiter_rr

Parametrised N-channel memory arbiter. It sits between the pipeline/cache clients (instruction fetch, data cache, DMA and similar) and the single IOCTRL memory port. Each channel issues a read or write request. The block grants one channel at a time using either fixed priority or round-robin. It forwards the transaction to memory and returns data plus a one-cycle ack. An optional timeout terminates hung transactions with an error flag.

## Interface
Parameters:
- NUM_CH, 3: number of client channels (2..8).
- ADDR_W, 32: address width.
- DATA_W, 32: data width.
- RR_MODE, 1: 1 = round-robin; 0 = fixed priority, where the lowest channel index wins.
- TIMEOUT, 0: maximum number of BUSY cycles before forced termination; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- ch_req  in  NUM_CH  request per channel; bit i belongs to channel i.
- ch_we  in  NUM_CH  1 = write, 0 = read; valid while ch_req[i] is high.
- ch_addr  in  NUM_CH*ADDR_W  channel i uses bits [i*ADDR_W +: ADDR_W].
- ch_wdata  in  NUM_CH*DATA_W  write data, packed like ch_addr.
- ch_ack  out  NUM_CH  one-cycle completion pulse, registered.
- ch_err  out  NUM_CH  one-cycle pulse coincident with ch_ack when the transaction timed out.
- ch_rdata  out  DATA_W  read data; valid in the ch_ack cycle; shared by all channels.
- grant  out  clog2(NUM_CH)  index of the channel currently or most recently served.
- busy  out  1  high in BUSY and DONE states.
- mem_read  out  1  memory read strobe, registered.
- mem_write  out  1  memory write strobe, registered.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_data_write  out  DATA_W  memory write data, registered.
- mem_ack  in  1  memory completion; sampled only in BUSY.
- mem_data_read  in  DATA_W  memory read data; valid when mem_ack is high.

## Operation
- States:
  - IDLE: arbitrate.
  - BUSY: memory transaction outstanding.
  - DONE: one-cycle ack/recovery slot.
- IDLE, when any ch_req bit is high:
  - Select winner w.
  - Register mem_addr, mem_data_write (writes only), and mem_read/mem_write from ch_we[w].
  - Set grant=w and go to BUSY.
- IDLE, when no ch_req bit is high: stay in IDLE; all strobes low.
- Fixed priority: w is the lowest index i with ch_req[i]=1.
- Round-robin:
  - Search starts at ptr+1 and wraps modulo NUM_CH.
  - ptr updates to w on each grant.
  - ptr resets to NUM_CH-1, so channel 0 wins the first contention.
- BUSY:
  - Strobes, address and write data are held constant.
  - Timeout counter increments each cycle.
  - On mem_ack: drop both strobes. Latch ch_rdata = mem_data_read (reads only; writes leave ch_rdata unchanged). Set ch_ack[grant]=1 in the next cycle. Go to DONE.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT with no mem_ack: drop strobes, set ch_rdata=0, pulse ch_ack[grant] and ch_err[grant], go to DONE.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT, mem_ack wins and no error is raised.
- DONE:
  - ch_ack is high for this single cycle.
  - Counter clears.
  - Unconditional transition to IDLE.
- Client rule: the client holds ch_req, ch_we, ch_addr and ch_wdata stable until its ack. It must deassert ch_req in the cycle after the ack cycle, unless it wants a new transaction.
- Requests from non-granted channels are ignored, not queued; they wait in place.
- Counter width is clog2(TIMEOUT+1). When TIMEOUT=0 the counter logic is absent.
- Reset mid-transaction:
  - All outputs clear immediately and the state becomes IDLE.
  - An in-flight mem_ack after reset is ignored, because it is seen only in BUSY.

## Timing
- Reset values:
  - State IDLE; ptr=NUM_CH-1.
  - ch_ack=0, ch_err=0, ch_rdata=0.
  - grant=0, busy=0.
  - mem_read=0, mem_write=0, mem_addr=0, mem_data_write=0.
- Cycle 0: request is seen in IDLE. Cycle 1: strobes are high (BUSY).
- If mem_ack is high in cycle k, then in cycle k+1 the strobes are low and ch_ack is high (DONE). Cycle k+2 is IDLE again.
- The next grant's strobes appear at the earliest in cycle k+3.
- Minimum transaction with mem_ack in cycle 1 occupies 4 cycles from request to next possible grant.
- With timeout, ch_ack/ch_err assert in the cycle after BUSY cycle number TIMEOUT.

## Test plan
- Single read, ch1 addr 0x100, mem_ack after 3 cycles with data 0xDEADBEEF:
  - mem_read is high for exactly 3 cycles and mem_addr=0x100.
  - ch_ack=3'b010 for 1 cycle with ch_rdata=0xDEADBEEF.
- Write, ch0 addr 0x40 data 0x12345678, mem_ack immediate:
  - mem_write=1, mem_data_write=0x12345678.
  - ch_ack[0] pulses; ch_rdata is unchanged.
- RR_MODE=1, all three channels requesting continuously (each re-requests after its ack): grants occur in order 0,1,2,0,1,2.
- RR_MODE=0, same stimulus: ch0 is granted every time, while ch1 and ch2 continue to wait.
- TIMEOUT=4, mem_ack is never asserted:
  - The strobe is high for 4 cycles.
  - ch_ack and ch_err pulse together, ch_rdata=0, and the block returns to IDLE.
  - Also cover mem_ack in the 4th cycle: ack is raised with no err.
- Reset asserted in the middle of BUSY, followed by a late mem_ack:
  - Outputs go to reset values asynchronously.
  - No ch_ack is produced; the next request is granted normally.
